rs_age_multi_cdb: RTL and testbench

//  Parametrised reservation station for the Tomasulo core, between Issue and the ALU.

---
 rtl/rs_age_multi_cdb_pkg.sv | 43 ++++
 rtl/rs_age_multi_cdb_select.sv | 28 ++
 rtl/rs_age_multi_cdb.sv | 136 +++++++++++++
 tb/tb_rs_age_multi_cdb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_multi_cdb_pkg.sv
// Shared widths, entry payload types and the CDB wakeup helper for the
// age-ordered multi-CDB reservation station.
package rs_age_multi_cdb_pkg;

   localparam int unsigned RS_DEPTH = 16;
   localparam int unsigned ROB_W    = 4;
   localparam int unsigned OP_W     = 6;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned N_CDB    = 2;
   localparam int unsigned CNT_W    = $clog2(RS_DEPTH + 1);
   localparam int unsigned IDX_W    = $clog2(RS_DEPTH);

   typedef struct packed {
      logic            rdy;
      logic [XLEN-1:0] val;
   } opnd_t;

   typedef struct packed {
      logic [OP_W-1:0]  opcode;
      opnd_t            rs1;
      opnd_t            rs2;
      logic [ROB_W-1:0] name;
   } rs_entry_t;

   // Capture a CDB result for an unready operand; bus 0 is visited last so it wins.
   function automatic opnd_t cdb_wake(input logic                   rdy,
                                      input logic [XLEN-1:0]        val,
                                      input logic [N_CDB-1:0]       sgn,
                                      input logic [N_CDB*XLEN-1:0]  res,
                                      input logic [N_CDB*ROB_W-1:0] name);
      opnd_t o;
      o.rdy = rdy;
      o.val = val;
      for (int k = int'(N_CDB) - 1; k >= 0; k--) begin
         if (!rdy && sgn[k] && (val[ROB_W-1:0] == name[k*ROB_W +: ROB_W])) begin
            o.rdy = 1'b1;
            o.val = res[k*XLEN +: XLEN];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/rs_age_multi_cdb_select.sv
// Oldest-ready picker: one-hot grant of the ready entry that no other ready entry is older than.
module rs_age_multi_cdb_select
   import rs_age_multi_cdb_pkg::*;
(
   input  logic [RS_DEPTH-1:0]               ready,
   input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age,
   output logic [RS_DEPTH-1:0]               grant_c,
   output logic                              any_c
);

   logic blocked;

   // age[j][i]=1 means j is older than i, so a ready j blocks i.
   always_comb begin
      grant_c = '0;
      blocked = 1'b0;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
         blocked = 1'b0;
         for (int j = 0; j < int'(RS_DEPTH); j++) begin
            blocked = blocked | (ready[j] & age[j][i]);
         end
         grant_c[i] = ready[i] & ~blocked;
      end
   end

   assign any_c = |ready;

endmodule

// File: rtl/rs_age_multi_cdb.sv
// Reservation station between Issue and the ALU: N_CDB operand wakeup with
// issue-time bypass, oldest-ready dispatch via an age matrix, flush and ALU backpressure.
module rs_age_multi_cdb
   import rs_age_multi_cdb_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic                     IS_sgn,
   input  logic [OP_W-1:0]          IS_opcode,
   input  logic [XLEN-1:0]          IS_rs1_val,
   input  logic                     IS_rs1_rdy,
   input  logic [XLEN-1:0]          IS_rs2_val,
   input  logic                     IS_rs2_rdy,
   input  logic [ROB_W-1:0]         IS_rob_name,
   output logic                     IS_RS_full,
   input  logic                     ALU_stall,
   output logic                     ALU_sgn,
   output logic [OP_W-1:0]          ALU_opcode,
   output logic [ROB_W-1:0]         ALU_name,
   output logic [XLEN-1:0]          ALU_lhs,
   output logic [XLEN-1:0]          ALU_rhs,
   input  logic [N_CDB-1:0]         CDB_sgn,
   input  logic [N_CDB*XLEN-1:0]    CDB_result,
   input  logic [N_CDB*ROB_W-1:0]   CDB_name
);

   logic [RS_DEPTH-1:0]               busy_q, busy_nxt;
   rs_entry_t                         ent_q [RS_DEPTH];
   logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q;
   logic [CNT_W-1:0]                  count_q, count_nxt;
   logic [RS_DEPTH-1:0]               ready, grant;
   logic                              any_ready, dispatch, alloc, free_any;
   logic [IDX_W-1:0]                  free_idx, grant_idx;
   rs_entry_t                         is_ent;

   // Lowest-index free entry; only registered busy counts, so a slot freed this edge waits a cycle.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_any = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      ready     = '0;
      grant_idx = '0;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
         ready[i] = busy_q[i] & ent_q[i].rs1.rdy & ent_q[i].rs2.rdy;
         if (grant[i]) grant_idx = grant_idx | IDX_W'(i);
      end
   end

   rs_age_multi_cdb_select u_select (
      .ready   (ready),
      .age     (age_q),
      .grant_c (grant),
      .any_c   (any_ready)
   );

   assign dispatch = any_ready & ~ALU_stall;
   assign alloc    = IS_sgn & free_any;

   // Incoming entry with same-cycle CDB bypass applied.
   always_comb begin
      is_ent.opcode = IS_opcode;
      is_ent.rs1    = cdb_wake(IS_rs1_rdy, IS_rs1_val, CDB_sgn, CDB_result, CDB_name);
      is_ent.rs2    = cdb_wake(IS_rs2_rdy, IS_rs2_val, CDB_sgn, CDB_result, CDB_name);
      is_ent.name   = IS_rob_name;
   end

   always_comb begin
      busy_nxt = busy_q;
      if (dispatch) busy_nxt = busy_nxt & ~grant;
      if (alloc)    busy_nxt[free_idx] = 1'b1;
      count_nxt = count_q + CNT_W'(alloc) - CNT_W'(dispatch);
   end

   // Entry payloads need no reset: busy qualifies every use.
   always_ff @(posedge clk) begin
      if (rdy && !flush) begin
         for (int i = 0; i < int'(RS_DEPTH); i++) begin
            ent_q[i].rs1 <= cdb_wake(ent_q[i].rs1.rdy, ent_q[i].rs1.val, CDB_sgn, CDB_result, CDB_name);
            ent_q[i].rs2 <= cdb_wake(ent_q[i].rs2.rdy, ent_q[i].rs2.val, CDB_sgn, CDB_result, CDB_name);
         end
         if (alloc) ent_q[free_idx] <= is_ent;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q     <= '0;
         age_q      <= '0;
         count_q    <= '0;
         IS_RS_full <= 1'b0;
         ALU_sgn    <= 1'b0;
         ALU_opcode <= '0;
         ALU_name   <= '0;
         ALU_lhs    <= '0;
         ALU_rhs    <= '0;
      end else if (rdy) begin
         if (flush) begin
            busy_q     <= '0;
            count_q    <= '0;
            IS_RS_full <= 1'b0;
            ALU_sgn    <= 1'b0;
         end else begin
            busy_q     <= busy_nxt;
            count_q    <= count_nxt;
            IS_RS_full <= (count_nxt >= CNT_W'(RS_DEPTH - 1));
            ALU_sgn    <= dispatch;
            if (dispatch) begin
               ALU_opcode <= ent_q[grant_idx].opcode;
               ALU_name   <= ent_q[grant_idx].name;
               ALU_lhs    <= ent_q[grant_idx].rs1.val;
               ALU_rhs    <= ent_q[grant_idx].rs2.val;
            end
            // New entry is younger than everything currently busy.
            if (alloc) begin
               for (int j = 0; j < int'(RS_DEPTH); j++) age_q[j][free_idx] <= busy_q[j];
               age_q[free_idx] <= '0;
            end
         end
      end
   end

   a_no_drop: assert property (@(posedge clk) disable iff (!rst)
                               (rdy && !flush && IS_sgn) |-> free_any)
      else $error("rs_age_multi_cdb: issue dropped with no free entry");

endmodule

// File: tb/tb_rs_age_multi_cdb.sv
// Bench for rs_age_multi_cdb: directed table, hand corner sequences and a random run
// against an age-ordered queue model.
module tb_rs_age_multi_cdb;
   import rs_age_multi_cdb_pkg::*;

   logic                   clk, rst, rdy, flush, is_sgn, rs1_rdy, rs2_rdy, alu_stall;
   logic [OP_W-1:0]        is_opcode;
   logic [XLEN-1:0]        rs1_val, rs2_val;
   logic [ROB_W-1:0]       is_name;
   logic                   is_full, alu_sgn;
   logic [OP_W-1:0]        alu_opcode;
   logic [ROB_W-1:0]       alu_name;
   logic [XLEN-1:0]        alu_lhs, alu_rhs;
   logic [N_CDB-1:0]       cdb_sgn;
   logic [N_CDB*XLEN-1:0]  cdb_result;
   logic [N_CDB*ROB_W-1:0] cdb_name;

   rs_age_multi_cdb dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .IS_sgn(is_sgn), .IS_opcode(is_opcode),
      .IS_rs1_val(rs1_val), .IS_rs1_rdy(rs1_rdy),
      .IS_rs2_val(rs2_val), .IS_rs2_rdy(rs2_rdy),
      .IS_rob_name(is_name), .IS_RS_full(is_full),
      .ALU_stall(alu_stall), .ALU_sgn(alu_sgn), .ALU_opcode(alu_opcode),
      .ALU_name(alu_name), .ALU_lhs(alu_lhs), .ALU_rhs(alu_rhs),
      .CDB_sgn(cdb_sgn), .CDB_result(cdb_result), .CDB_name(cdb_name)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: entries kept oldest-first.
   typedef struct {
      logic [OP_W-1:0]  op;
      logic [XLEN-1:0]  v1, v2;
      bit               r1, r2;
      logic [ROB_W-1:0] name;
   } m_ent_t;

   m_ent_t           mq[$];
   logic             e_sgn, e_full;
   logic [OP_W-1:0]  e_op;
   logic [ROB_W-1:0] e_name;
   logic [XLEN-1:0]  e_lhs, e_rhs;
   int               vec_cnt = 0;
   int               err_cnt = 0;

   typedef struct {
      logic                   is_sgn;
      logic [OP_W-1:0]        op;
      logic [XLEN-1:0]        v1;
      logic                   r1;
      logic [XLEN-1:0]        v2;
      logic                   r2;
      logic [ROB_W-1:0]       name;
      logic [N_CDB-1:0]       csgn;
      logic [N_CDB*XLEN-1:0]  cres;
      logic [N_CDB*ROB_W-1:0] cname;
      logic                   x_sgn;
      logic [OP_W-1:0]        x_op;
      logic [ROB_W-1:0]       x_name;
      logic [XLEN-1:0]        x_lhs, x_rhs;
   } vec_t;

   vec_t tbl[8];

   function automatic m_ent_t wake_ent(m_ent_t e);
      for (int k = 0; k < int'(N_CDB); k++) begin
         if (cdb_sgn[k]) begin
            if (!e.r1 && e.v1[ROB_W-1:0] == cdb_name[k*ROB_W +: ROB_W]) begin
               e.r1 = 1'b1;
               e.v1 = cdb_result[k*XLEN +: XLEN];
            end
            if (!e.r2 && e.v2[ROB_W-1:0] == cdb_name[k*ROB_W +: ROB_W]) begin
               e.r2 = 1'b1;
               e.v2 = cdb_result[k*XLEN +: XLEN];
            end
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      mq.delete();
      e_sgn = 0; e_full = 0; e_op = '0; e_name = '0; e_lhs = '0; e_rhs = '0;
   endtask

   task automatic model_step();
      int     sel;
      m_ent_t n;
      if (!rdy) return;
      if (flush) begin
         mq.delete();
         e_sgn  = 0;
         e_full = 0;
         return;
      end
      sel = -1;
      if (!alu_stall) begin
         for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
               sel = i;
               break;
            end
         end
      end
      if (sel >= 0) begin
         e_sgn = 1; e_op = mq[sel].op; e_name = mq[sel].name;
         e_lhs = mq[sel].v1; e_rhs = mq[sel].v2;
         mq.delete(sel);
      end else begin
         e_sgn = 0;
      end
      for (int i = 0; i < mq.size(); i++) mq[i] = wake_ent(mq[i]);
      if (is_sgn) begin
         n = '{op: is_opcode, v1: rs1_val, v2: rs2_val, r1: rs1_rdy, r2: rs2_rdy, name: is_name};
         mq.push_back(wake_ent(n));
      end
      e_full = (mq.size() >= int'(RS_DEPTH) - 1);
   endtask

   task automatic check_all(string tag);
      vec_cnt++;
      if ({alu_sgn, is_full, alu_opcode, alu_name, alu_lhs, alu_rhs} !==
          {e_sgn, e_full, e_op, e_name, e_lhs, e_rhs}) begin
         err_cnt++;
         $display("FAIL %s: got sgn=%0b full=%0b op=%0h name=%0h lhs=%0h rhs=%0h, want sgn=%0b full=%0b op=%0h name=%0h lhs=%0h rhs=%0h",
                  tag, alu_sgn, is_full, alu_opcode, alu_name, alu_lhs, alu_rhs,
                  e_sgn, e_full, e_op, e_name, e_lhs, e_rhs);
      end
   endtask

   task automatic check_val(string tag, logic [XLEN-1:0] got, logic [XLEN-1:0] want);
      vec_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   task automatic idle();
      is_sgn = 0; cdb_sgn = '0; flush = 0; rdy = 1;
   endtask

   task automatic issue(logic [OP_W-1:0] op, logic [XLEN-1:0] v1, logic r1,
                        logic [XLEN-1:0] v2, logic r2, logic [ROB_W-1:0] name);
      is_sgn = 1; is_opcode = op; rs1_val = v1; rs1_rdy = r1;
      rs2_val = v2; rs2_rdy = r2; is_name = name;
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      //            is op     v1      r1 v2     r2 name  csgn   cres                     cname         x: sgn op  name lhs     rhs
      tbl[0] = '{1, 6'd1, 32'd5, 1, 32'd7, 1, 4'd1, 2'b00, 64'd0,                   8'd0,          0, 6'd0, 4'd0, 32'd0,   32'd0};
      tbl[1] = '{0, 6'd0, 32'd0, 0, 32'd0, 0, 4'd0, 2'b00, 64'd0,                   8'd0,          1, 6'd1, 4'd1, 32'd5,   32'd7};
      tbl[2] = '{1, 6'd2, 32'd3, 0, 32'd9, 1, 4'd2, 2'b00, 64'd0,                   8'd0,          0, 6'd1, 4'd1, 32'd5,   32'd7};
      tbl[3] = '{0, 6'd0, 32'd0, 0, 32'd0, 0, 4'd0, 2'b00, 64'd0,                   8'd0,          0, 6'd1, 4'd1, 32'd5,   32'd7};
      tbl[4] = '{0, 6'd0, 32'd0, 0, 32'd0, 0, 4'd0, 2'b10, {32'hAA, 32'h0},         {4'd3, 4'd0},  0, 6'd1, 4'd1, 32'd5,   32'd7};
      tbl[5] = '{0, 6'd0, 32'd0, 0, 32'd0, 0, 4'd0, 2'b00, 64'd0,                   8'd0,          1, 6'd2, 4'd2, 32'hAA,  32'd9};
      tbl[6] = '{1, 6'd3, 32'd2, 0, 32'd4, 1, 4'd3, 2'b01, {32'h0, 32'h55},         {4'd0, 4'd2},  0, 6'd2, 4'd2, 32'hAA,  32'd9};
      tbl[7] = '{0, 6'd0, 32'd0, 0, 32'd0, 0, 4'd0, 2'b00, 64'd0,                   8'd0,          1, 6'd3, 4'd3, 32'h55,  32'd4};

      rst = 0; alu_stall = 0; idle();
      is_opcode = '0; rs1_val = '0; rs2_val = '0; rs1_rdy = 0; rs2_rdy = 0; is_name = '0;
      cdb_result = '0; cdb_name = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1;
      check_all("reset_state");

      // Activity, then an asynchronous reset mid-cycle with a ready entry pending.
      issue(6'h3, 32'h11, 1, 32'h22, 1, 4'd5); tick("pre_issue");
      idle(); tick("pre_dispatch");
      alu_stall = 1;
      issue(6'h4, 32'd5, 1, 32'd7, 1, 4'd6); tick("pre_issue_stalled");
      idle(); tick("pre_stalled_hold");
      #2 rst = 0;
      #1 model_reset();
      check_all("async_reset");
      @(posedge clk);
      #1 rst = 1; alu_stall = 0; idle();

      // Directed table: basic dispatch, CDB1 wakeup, issue-time bypass on CDB0.
      for (int i = 0; i < 8; i++) begin
         is_sgn = tbl[i].is_sgn; is_opcode = tbl[i].op; rs1_val = tbl[i].v1; rs1_rdy = tbl[i].r1;
         rs2_val = tbl[i].v2; rs2_rdy = tbl[i].r2; is_name = tbl[i].name;
         cdb_sgn = tbl[i].csgn; cdb_result = tbl[i].cres; cdb_name = tbl[i].cname;
         @(posedge clk);
         model_step();
         #1;
         vec_cnt++;
         if (alu_sgn !== tbl[i].x_sgn || alu_opcode !== tbl[i].x_op || alu_name !== tbl[i].x_name ||
             alu_lhs !== tbl[i].x_lhs || alu_rhs !== tbl[i].x_rhs || is_full !== 1'b0) begin
            err_cnt++;
            $display("FAIL tbl[%0d]: got sgn=%0b op=%0h name=%0h lhs=%0h rhs=%0h full=%0b, want sgn=%0b op=%0h name=%0h lhs=%0h rhs=%0h full=0",
                     i, alu_sgn, alu_opcode, alu_name, alu_lhs, alu_rhs, is_full,
                     tbl[i].x_sgn, tbl[i].x_op, tbl[i].x_name, tbl[i].x_lhs, tbl[i].x_rhs);
         end
      end
      idle();

      // Two entries on tag 4, woken together; both buses match, bus 0 must win.
      issue(6'd5, 32'd4, 0, 32'd1, 1, 4'd8); tick("age_issue_a");
      issue(6'd6, 32'd4, 0, 32'd2, 1, 4'd9); tick("age_issue_b");
      idle(); cdb_sgn = 2'b11; cdb_name = {4'd4, 4'd4}; cdb_result = {32'h99, 32'h44};
      tick("age_wake");
      idle(); tick("age_first");
      check_val("age_older_first", {28'd0, alu_name}, 32'd8);
      check_val("age_low_bus_wins", alu_lhs, 32'h44);
      tick("age_second");
      check_val("age_younger_next", {28'd0, alu_name}, 32'd9);
      check_val("age_second_sgn", {31'd0, alu_sgn}, 32'd1);
      tick("age_drained");

      // Fill to the full threshold under stall, hold, then drain one per cycle.
      alu_stall = 1;
      for (int i = 0; i < int'(RS_DEPTH) - 1; i++) begin
         issue(6'(i), 32'(100 + i), 1, 32'(200 + i), 1, 4'(i));
         tick("fill");
      end
      idle();
      check_val("full_at_threshold", {31'd0, is_full}, 32'd1);
      check_val("stall_no_sgn", {31'd0, alu_sgn}, 32'd0);
      repeat (3) tick("stall_hold");
      alu_stall = 0;
      for (int i = 0; i < int'(RS_DEPTH) - 1; i++) begin
         tick("drain");
         check_val("drain_order", {28'd0, alu_name}, 32'(i));
      end
      check_val("full_dropped", {31'd0, is_full}, 32'd0);
      tick("drain_done");

      // Flush with a same-cycle issue and CDB: everything discarded.
      alu_stall = 1;
      for (int i = 0; i < 3; i++) begin
         issue(6'd7, 32'd1, 1, 32'd2, 0, 4'(i)); tick("pre_flush");
      end
      issue(6'd9, 32'd3, 1, 32'd4, 1, 4'd12);
      cdb_sgn = 2'b11; cdb_name = {4'd2, 4'd2}; cdb_result = {32'h5, 32'h6};
      flush = 1;
      tick("flush");
      check_val("flush_sgn", {31'd0, alu_sgn}, 32'd0);
      idle(); alu_stall = 0;
      cdb_sgn = 2'b01; cdb_name = {4'd0, 4'd2};
      tick("post_flush_cdb");
      idle();
      repeat (2) tick("post_flush_idle");
      check_val("flush_nothing_left", {31'd0, alu_sgn}, 32'd0);

      // Randomised run against the model.
      for (int c = 0; c < 3000; c++) begin
         rdy       = ($urandom_range(0, 9) != 0);
         flush     = ($urandom_range(0, 59) == 0);
         alu_stall = ($urandom_range(0, 3) == 0);
         is_sgn    = (mq.size() < int'(RS_DEPTH) - 1) && ($urandom_range(0, 1) == 1);
         is_opcode = 6'($urandom);
         is_name   = 4'($urandom);
         rs1_rdy   = ($urandom_range(0, 2) != 0);
         rs2_rdy   = ($urandom_range(0, 2) != 0);
         rs1_val   = $urandom;
         rs2_val   = $urandom;
         if (!rs1_rdy) rs1_val[ROB_W-1:0] = 4'($urandom_range(0, 3));
         if (!rs2_rdy) rs2_val[ROB_W-1:0] = 4'($urandom_range(0, 3));
         cdb_sgn    = 2'($urandom);
         cdb_name   = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         cdb_result = {$urandom, $urandom};
         tick("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
